// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan for a 4-digit 7-segment display.
// Drives the active-low enable and select lines of a 2-to-4 digit decoder and
// presents the BCD nibble / decimal point of the selected digit.  Each digit
// slot is GUARD_CYCLES with the decoder disabled followed by SHOW_CYCLES with
// it enabled, so select changes only ever happen while the decoder is off.
// The digit values are captured once per frame so a frame is never torn.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (never digit 0) keep the decoder disabled
//   undefined -> all four digits are always shown
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_GUARD | decoder disabled; settle time before showing digit sel
//   ST_SHOW  | decoder enabled (unless blanked); digit sel is lit

module display_scan_ctrl #(
    parameter int SHOW_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        blank_req,
    output logic        en,
    output logic        a,
    output logic        b,
    output logic [3:0]  seg_bcd,
    output logic        dp
);

    localparam int MAX_CYC = (SHOW_CYCLES > GUARD_CYCLES) ? SHOW_CYCLES : GUARD_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    sel_q,   sel_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [15:0]   snap_q,  snap_d;
    logic [3:0]    snap_dp_q, snap_dp_d;
    logic          blank_q;
    logic          snap_take;
    logic          lz_blank;

    // Start of frame: guard interval of digit 0 with a fresh count.
    assign snap_take = (state_q == ST_GUARD) && (sel_q == 2'd0) && (cnt_q == '0);

    // Slot sequencing: guard then show for each digit, advancing sel after show.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q + CW'(1);
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        if (state_q == ST_GUARD) begin
            if (cnt_q == GUARD_LAST) begin
                cnt_d   = '0;
                state_d = ST_SHOW;
            end
        end else begin
            if (cnt_q == SHOW_LAST) begin
                cnt_d   = '0;
                state_d = ST_GUARD;
                sel_d   = sel_q + 2'd1;
            end
        end
        if (snap_take) begin
            snap_d    = digits;
            snap_dp_d = dp_mask;
        end
    end

    // State registers with immediate clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_GUARD;
            sel_q     <= 2'd0;
            cnt_q     <= '0;
            snap_q    <= 16'd0;
            snap_dp_q <= 4'd0;
            blank_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            blank_q   <= blank_req;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Suppress digit sel when it and every more-significant digit are zero.
    always_comb begin
        lz_blank = 1'b0;
        case (sel_q)
            2'd1:    lz_blank = (snap_q[15:4]  == 12'd0);
            2'd2:    lz_blank = (snap_q[15:8]  == 8'd0);
            2'd3:    lz_blank = (snap_q[15:12] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Nibble of the selected digit from the frame snapshot.
    always_comb begin
        seg_bcd = snap_q[3:0];
        case (sel_q)
            2'd0:    seg_bcd = snap_q[3:0];
            2'd1:    seg_bcd = snap_q[7:4];
            2'd2:    seg_bcd = snap_q[11:8];
            default: seg_bcd = snap_q[15:12];
        endcase
    end

    assign en = (state_q != ST_SHOW) | blank_q | lz_blank;
    assign a  = sel_q[1];
    assign b  = sel_q[0];
    assign dp = snap_dp_q[sel_q] & ~en;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-position model.
// Build with +define+LEADING_ZERO_BLANK_EN to exercise the leading-zero option.

module tb_display_scan_ctrl;

    localparam int G     = 2;
    localparam int S     = 4;
    localparam int SLOT  = G + S;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank_req;
    logic        en, a, b, dp;
    logic [3:0]  seg_bcd;

    display_scan_ctrl #(.SHOW_CYCLES(S), .GUARD_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask),
        .blank_req(blank_req), .en(en), .a(a), .b(b),
        .seg_bcd(seg_bcd), .dp(dp)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model: edges since reset release plus captured frame data
    int          k;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;
    logic        m_blank;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, obs, exp, $time, k);
        end
    endtask

    task automatic model_reset();
        k       = 0;
        m_snap  = 16'd0;
        m_dp    = 4'd0;
        m_blank = 1'b0;
    endtask

    task automatic check_outputs();
        int   pos, slot;
        logic show, lz, en_e;
        logic [3:0] nib;
        pos  = k % FRAME;
        slot = pos / SLOT;
        show = (pos % SLOT) >= G;
        nib  = 4'((m_snap >> (4 * slot)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
        lz = (slot != 0) && ((m_snap >> (4 * slot)) == 16'd0);
`else
        lz = 1'b0;
`endif
        en_e = !show || m_blank || lz;
        chk("en", 32'(en), 32'(en_e));
        chk("a", 32'(a), 32'((slot >> 1) & 1));
        chk("b", 32'(b), 32'(slot & 1));
        chk("seg_bcd", 32'(seg_bcd), 32'(nib));
        chk("dp", 32'(dp), 32'(m_dp[slot] & !en_e));
    endtask

    // Effect of the next rising edge given the inputs now applied.
    task automatic step_model();
        if (k % FRAME == 0) begin
            m_snap = digits;
            m_dp   = dp_mask;
        end
        m_blank = blank_req;
        k++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"},  32'(en),      32'd1);
        chk({tag, "_a"},   32'(a),       32'd0);
        chk({tag, "_b"},   32'(b),       32'd0);
        chk({tag, "_seg"}, 32'(seg_bcd), 32'd0);
        chk({tag, "_dp"},  32'(dp),      32'd0);
    endtask

    function automatic logic [15:0] pick_digits();
        case ($urandom_range(0, 5))
            0:       return 16'h0070;
            1:       return 16'h0000;
            2:       return 16'h1234;
            3:       return 16'h0500;
            default: return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        endcase
    endfunction

    int blank_left;

    initial begin
        rst_n      = 1'b0;
        digits     = 16'h1234;
        dp_mask    = 4'b0100;
        blank_req  = 1'b0;
        blank_left = 0;
        model_reset();
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            check_outputs();

            if (cyc == 700 || (cyc > 100 && $urandom_range(0, 399) == 0)) begin
                #3;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                model_reset();
                @(negedge clk);
                @(negedge clk);
                check_reset_outputs("rst_hold");
                rst_n = 1'b1;
                check_outputs();
            end

            if ($urandom_range(0, 29) == 0) begin
                digits  = pick_digits();
                dp_mask = 4'($urandom_range(0, 15));
            end
            if (blank_left > 0) begin
                blank_left--;
                blank_req = (blank_left > 0);
            end else if ($urandom_range(0, 39) == 0) begin
                blank_left = $urandom_range(1, 4);
                blank_req  = 1'b1;
            end else begin
                blank_req = 1'b0;
            end

            step_model();
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
